multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle MIPS core. Decodes the instruction
//  opcode, sequences fetch/decode/execute/memory/writeback, and drives the
//  2-bit aluop into alu_control. Also drives the ALU operand muxes, the PC
//  and memory enables, and the register-file enables. Handshakes with
//  memory through mem_ready, with a bounded wait.
// PARAMETERS
//  TIMEOUT   16   max cycles to wait for mem_ready before aborting (>=2)
//  CNT_W     32   width of retired-instruction counter
// PORTS
//  clk          in   1      core clock, all state changes on rising edge
//  rst_n        in   1      synchronous active-low reset
//  opcode       in   6      instr[31:26] from IR
//  mem_ready    in   1      memory has completed current read/write this cycle
//  aluop        out  2      00 add, 01 sub, 10 use funct (to alu_control)
//  alusrca      out  1      0 PC, 1 reg A
//  alusrcb      out  2      00 reg B, 01 const 4, 10 signimm, 11 signimm<<2
//  pcsrc        out  2      00 ALU result, 01 ALUOut, 10 jump target
//  pcwrite      out  1      unconditional PC write
//  branch       out  1      PC write qualified by zero (beq)
//  iord         out  1      0 address=PC, 1 address=ALUOut
//  memread      out  1      memory read request
//  memwrite     out  1      memory write request
//  irwrite      out  1      load IR
//  regdst       out  1      0 rt, 1 rd
//  memtoreg     out  1      0 ALUOut, 1 MDR
//  regwrite     out  1      register file write
//  illegal_op   out  1      1-cycle pulse: undecodable opcode in DECODE
//  mem_timeout  out  1      1-cycle pulse: memory wait aborted
//  retired      out  CNT_W  count of completed instructions
//  state_dbg    out  4      current state encoding
// BEHAVIOUR
//  - States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 RTEX=6 RTWB=7
//    BEQEX=8 ADDIEX=9 ADDIWB=10 JEX=11.
//  - Reset: rst_n=0 at an edge sets state=FETCH, wait counter=0, retired=0.
//    While rst_n=0, all enables (pcwrite, branch, memread, memwrite, irwrite,
//    regwrite, pulses) are forced 0. The mux selects and aluop are 0.
//  - Outputs are a Moore decode of state. Only the pulses are registered.
//  - FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
//    irwrite=1 and pcwrite=1 only in the cycle mem_ready=1. Then -> DECODE.
//  - DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target precompute).
//    Opcode dispatch: 100011/101011 -> MEMADR, 000000 -> RTEX,
//    000100 -> BEQEX, 001000 -> ADDIEX, 000010 -> JEX. Any other opcode ->
//    FETCH with illegal_op pulsed next cycle. Illegal ops do not count as retired.
//  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Then -> MEMRD for lw, MEMWR for sw.
//  - MEMRD: iord=1, memread=1. Holds until mem_ready, then -> MEMWB.
//  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Then -> FETCH.
//  - MEMWR: iord=1, memwrite=1. Holds until mem_ready, then -> FETCH.
//  - RTEX: alusrca=1, alusrcb=00, aluop=10. RTWB: regdst=1, memtoreg=0,
//    regwrite=1. Then -> FETCH.
//  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Then -> FETCH.
//  - ADDIEX: alusrca=1, alusrcb=10, aluop=00. ADDIWB: regdst=0,
//    memtoreg=0, regwrite=1. Then -> FETCH.
//  - JEX: pcsrc=10, pcwrite=1. Then -> FETCH.
//  - Latency per instruction with mem_ready tied high:
//    lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.
//  - Wait counter counts cycles spent in FETCH, MEMRD or MEMWR and clears
//    on any state change. If it reaches TIMEOUT-1 without mem_ready:
//    -> FETCH, mem_timeout pulsed next cycle, no enables fired, no retire.
//    The transition is FETCH->FETCH when the stall is in FETCH.
//  - mem_ready is sampled only in FETCH/MEMRD/MEMWR and ignored elsewhere.
//  - retired increments by 1 on each entry to FETCH from MEMWB, MEMWR,
//    RTWB, BEQEX, ADDIWB or JEX. It wraps modulo 2^CNT_W.
//  - rst_n low mid-instruction: abandons it, returns to FETCH, no retire.
// TESTING
//  1. Reset, mem_ready=1, opcode=000000 -> states 0,1,6,7,0. aluop=10 in
//     RTEX. regwrite=1, regdst=1 in RTWB. retired=1.
//  2. opcode=100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4
//     cycles. memread=1, iord=1 throughout. MEMWB then follows, retired+1.
//  3. opcode=000100 -> aluop=01, branch=1 in BEQEX only. 3-cycle instruction.
//  4. opcode=111111 in DECODE -> FETCH next, illegal_op=1 one cycle,
//     retired unchanged.
//  5. TIMEOUT=4, mem_ready=0 in MEMWR -> after 4 cycles -> FETCH,
//     mem_timeout pulse, memwrite drops, retired unchanged.
//  6. rst_n=0 for 1 cycle during MEMRD -> state FETCH, retired=0, all
//     enables 0 during reset cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback, drives datapath selects and enables, and bounds memory waits.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic [1:0]       aluop,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic             pcwrite,
    output logic             branch,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JEX    = 4'd11
    } state_t;

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_retired;
    logic               r_illegal;
    logic               r_timeout;

    state_t             w_next;
    logic               w_wait_done;
    logic               w_timeout;
    logic               w_illegal;
    logic               w_retire;

    assign w_wait_done = (r_wait == WAIT_W'(TIMEOUT - 1));

    // NOTE: every signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        w_illegal = 1'b0;
        w_retire  = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)        w_next = S_DECODE;
                else if (w_wait_done) begin w_next = S_FETCH; w_timeout = 1'b1; end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RT:        w_next = S_RTEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default:      begin w_next = S_FETCH; w_illegal = 1'b1; end
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)        w_next = S_MEMWB;
                else if (w_wait_done) begin w_next = S_FETCH; w_timeout = 1'b1; end
            end
            S_MEMWR: begin
                if (mem_ready)        begin w_next = S_FETCH; w_retire = 1'b1; end
                else if (w_wait_done) begin w_next = S_FETCH; w_timeout = 1'b1; end
            end
            S_RTEX:   w_next = S_RTWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_RTWB, S_BEQEX, S_ADDIWB, S_JEX: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            default:  w_next = S_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_retired <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illegal;
            r_timeout <= w_timeout;
            // A timeout restarts the count even when the state stays in FETCH.
            if (w_next == r_state && !w_timeout &&
                (r_state == S_FETCH || r_state == S_MEMRD || r_state == S_MEMWR))
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;
            if (w_retire)
                r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        aluop    = 2'b00;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        iord     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        case (r_state)
            S_FETCH:  begin memread = 1'b1; alusrcb = 2'b01; irwrite = mem_ready; pcwrite = mem_ready; end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin alusrca = 1'b1; alusrcb = 2'b10; end
            S_MEMRD:  begin iord = 1'b1; memread = 1'b1; end
            S_MEMWB:  begin memtoreg = 1'b1; regwrite = 1'b1; end
            S_MEMWR:  begin iord = 1'b1; memwrite = 1'b1; end
            S_RTEX:   begin alusrca = 1'b1; aluop = 2'b10; end
            S_RTWB:   begin regdst = 1'b1; regwrite = 1'b1; end
            S_BEQEX:  begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
            S_ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; end
            S_ADDIWB: regwrite = 1'b1;
            S_JEX:    begin pcsrc = 2'b10; pcwrite = 1'b1; end
            default:  ;
        endcase
        // Reset overrides the decode so nothing fires while the core is held.
        if (!rst_n) begin
            aluop    = 2'b00;
            alusrca  = 1'b0;
            alusrcb  = 2'b00;
            pcsrc    = 2'b00;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            iord     = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            regwrite = 1'b0;
        end
    end

    assign illegal_op  = r_illegal & rst_n;
    assign mem_timeout = r_timeout & rst_n;
    assign retired     = r_retired;
    assign state_dbg   = r_state;

endmodule
